// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter/sequencer sharing one spi_master
// between NREQ register-bus requesters. Each transaction is latched at
// grant and issued with a one-cycle start pulse. The arbiter then waits
// for the master's sticky done flag to clear and set again, and answers
// the requester with a one-cycle ack.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a per-transaction timeout
// that forces a response with rsp_err = 1.
module spi_master_arb #(
  parameter int          NREQ        = 4,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  input  logic [9:0]           cfg_freq,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 spi_start_wr,
  output logic                 spi_start_re,
  output logic [7:0]           spi_addr,
  output logic [7:0]           spi_wdata,
  output logic [9:0]           spi_freq,
  input  logic                 spi_done,
  input  logic [7:0]           spi_rdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_gnt, last_gnt_nxt;
  logic            spi_rw, rw_nxt;
  logic [7:0]      addr_nxt, wdata_nxt, rdata_nxt;
  logic [9:0]      freq_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic            start_wr_nxt, start_re_nxt, busy_nxt;
  logic            timeout, to_hit;
  logic            found;
  logic [GW-1:0]   pick;
  int              rr_idx;

  // Round-robin search: first pending request after the last grant, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_gnt) + k) % NREQ;
      if (!found && req[GW'(rr_idx)]) begin
        found = 1'b1;
        pick  = GW'(rr_idx);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [19:0] to_cnt;

  // Per-transaction cycle counter: cleared when a transaction is issued, runs while waiting on the master.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)
      to_cnt <= '0;
    else if (state_nxt == ISSUE)
      to_cnt <= '0;
    else if (state == WAIT_CLR || state == WAIT_DONE)
      to_cnt <= to_cnt + 20'd1;
  end

  assign timeout = (state == WAIT_CLR || state == WAIT_DONE) && (to_cnt >= TIMEOUT_CYC);

  // Error flag registered alongside ack so it is valid in the ack cycle.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)
      rsp_err <= 1'b0;
    else
      rsp_err <= to_hit;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    rw_nxt       = spi_rw;
    addr_nxt     = spi_addr;
    wdata_nxt    = spi_wdata;
    freq_nxt     = spi_freq;
    to_hit       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = ISSUE;
          last_gnt_nxt = pick;
          rw_nxt       = req_rw[pick];
          addr_nxt     = req_addr[int'(pick)*8 +: 8];
          wdata_nxt    = req_wdata[int'(pick)*8 +: 8];
          freq_nxt     = cfg_freq;
        end
      end
      ISSUE:     state_nxt = WAIT_CLR;
      WAIT_CLR: begin
        // done is sticky from the previous transfer; wait for the master to clear it
        if (timeout) begin
          state_nxt = RESP;
          to_hit    = 1'b1;
        end else if (!spi_done) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          state_nxt = RESP;
        end else if (timeout) begin
          state_nxt = RESP;
          to_hit    = 1'b1;
        end
      end
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    start_wr_nxt = (state_nxt == ISSUE) && rw_nxt;
    start_re_nxt = (state_nxt == ISSUE) && !rw_nxt;
    busy_nxt     = (state_nxt != IDLE);
    ack_nxt      = (state_nxt == RESP) ? (NREQ'(1) << last_gnt_nxt) : '0;
    rdata_nxt    = (state_nxt == RESP && !spi_rw && !to_hit) ? spi_rdata : 8'h00;
  end

  // State, grant pointer and all registered outputs; reset aborts any transaction.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      last_gnt     <= GW'(NREQ - 1);
      spi_rw       <= 1'b0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
      spi_freq     <= '0;
      spi_start_wr <= 1'b0;
      spi_start_re <= 1'b0;
      busy         <= 1'b0;
      ack          <= '0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_nxt;
      last_gnt     <= last_gnt_nxt;
      spi_rw       <= rw_nxt;
      spi_addr     <= addr_nxt;
      spi_wdata    <= wdata_nxt;
      spi_freq     <= freq_nxt;
      spi_start_wr <= start_wr_nxt;
      spi_start_re <= start_re_nxt;
      busy         <= busy_nxt;
      ack          <= ack_nxt;
      rsp_rdata    <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Testbench for spi_master_arb: table of single transactions plus
// directed sequences for contention, fairness, reset mid-transfer and
// (with SPI_ARB_TIMEOUT_EN) timeout. A small behavioural model stands in
// for spi_master's done/rdata handshake.
module tb_spi_master_arb;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [19:0] TO = 20'd100;
`else
  localparam logic [19:0] TO = 20'd200000;
`endif

  logic        clock, n_reset;
  logic [3:0]  req, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic [9:0]  cfg_freq;
  logic [3:0]  ack;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, busy, spi_start_wr, spi_start_re;
  logic [7:0]  spi_addr, spi_wdata;
  logic [9:0]  spi_freq;
  logic        spi_done;
  logic [7:0]  spi_rdata;

  spi_master_arb #(.NREQ(4), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .n_reset(n_reset),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .cfg_freq(cfg_freq), .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .spi_start_wr(spi_start_wr), .spi_start_re(spi_start_re),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_freq(spi_freq),
    .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- master model ----------------
  logic       m_done, m_busy, m_start_d, hold_low;
  logic [7:0] m_rdata, slave_val;
  int         m_cnt;
  assign spi_done  = m_done;
  assign spi_rdata = m_rdata;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_start_d <= 1'b0; m_cnt <= 0; m_rdata <= 8'h00;
    end else begin
      m_start_d <= spi_start_wr | spi_start_re;
      if ((spi_start_wr | spi_start_re) && !m_start_d) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 1) m_done <= 1'b0;
        if (m_cnt == 10 && !hold_low) begin
          m_done  <= 1'b1;
          m_rdata <= slave_val;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int n_wr = 0, n_re = 0, overlap = 0, multi_ack = 0;
  always @(negedge clock) begin
    if (spi_start_wr) n_wr++;
    if (spi_start_re) n_re++;
    if ((spi_start_wr || spi_start_re) && (m_busy || (spi_start_wr && spi_start_re))) overlap++;
    if (!$onehot0(ack)) multi_ack++;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [9:0] freq;
    logic [7:0] sval;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vec[5];
  int   ack_log[8];
  int   ack_n;

  task automatic do_reset();
    @(negedge clock);
    n_reset = 1'b0;
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_txn(input int idx, input logic rw, input logic [7:0] a, input logic [7:0] w,
                        input logic [9:0] f, input logic [7:0] sv, input logic [7:0] exp_rd);
    int wr0, re0;
    bit seen, got;
    @(negedge clock);
    slave_val              = sv;
    req_addr[idx*8 +: 8]   = a;
    req_wdata[idx*8 +: 8]  = w;
    req_rw[idx]            = rw;
    cfg_freq               = f;
    req[idx]               = 1'b1;
    wr0 = n_wr; re0 = n_re; seen = 0; got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (!seen && (spi_start_wr || spi_start_re)) begin
        seen = 1;
        // changes after grant must be ignored
        req_addr[idx*8 +: 8]  = ~a;
        req_wdata[idx*8 +: 8] = ~w;
        req_rw[idx]           = ~rw;
        cfg_freq              = ~f;
      end
      if (ack != 4'b0) begin
        got = 1;
        break;
      end
    end
    check($sformatf("ack_seen[%0d]", idx), 32'(got), 32'd1);
    check($sformatf("ack_vec[%0d]", idx), 32'(ack), 32'(4'b1 << idx));
    check($sformatf("rdata[%0d]", idx), 32'(rsp_rdata), 32'(exp_rd));
    check($sformatf("err[%0d]", idx), 32'(rsp_err), 32'd0);
    check($sformatf("spi_addr[%0d]", idx), 32'(spi_addr), 32'(a));
    check($sformatf("spi_wdata[%0d]", idx), 32'(spi_wdata), 32'(w));
    check($sformatf("spi_freq[%0d]", idx), 32'(spi_freq), 32'(f));
    req[idx] = 1'b0;
    @(negedge clock);
    check($sformatf("ack_one_cycle[%0d]", idx), 32'(ack), 32'd0);
    check($sformatf("n_start_wr[%0d]", idx), 32'(n_wr - wr0), rw ? 32'd1 : 32'd0);
    check($sformatf("n_start_re[%0d]", idx), 32'(n_re - re0), rw ? 32'd0 : 32'd1);
  endtask

  // Apply req, log ack order, drop each acked line; re-raise lines in rearm one cycle later.
  task automatic collect(input int n, input logic [3:0] rearm);
    logic [3:0] pend;
    pend  = 4'b0;
    ack_n = 0;
    for (int c = 0; c < 1000 && ack_n < n; c++) begin
      @(negedge clock);
      req  = req | pend;
      pend = 4'b0;
      if (ack != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (ack[b]) begin
            if (ack_n < 8) ack_log[ack_n] = b;
            ack_n++;
          end
        req  = req & ~ack;
        pend = ack & rearm;
      end
    end
    req = 4'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!busy) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cont_exp[4];
    int fair_exp[4];
    int wr0, re0;
    bit bad, hit;
    cont_exp = '{0, 1, 2, 3};
    fair_exp = '{0, 3, 0, 3};
    vec[0] = '{0, 1'b0, 8'h3C, 8'h00, 10'd4,   8'hA5, 8'hA5};
    vec[1] = '{2, 1'b1, 8'h12, 8'h5A, 10'd4,   8'h77, 8'h00};
    vec[2] = '{1, 1'b0, 8'h80, 8'hFF, 10'h3FF, 8'h3C, 8'h3C};
    vec[3] = '{3, 1'b1, 8'hFF, 8'h01, 10'd1,   8'h99, 8'h00};
    vec[4] = '{3, 1'b0, 8'h00, 8'h00, 10'd0,   8'hFF, 8'hFF};

    n_reset = 1'b0; req = '0; req_rw = '0; req_addr = 32'hDEADBEEF; req_wdata = 32'hCAFEF00D;
    cfg_freq = 10'h155; slave_val = 8'h00; hold_low = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_start", 32'({spi_start_wr, spi_start_re}), 32'd0);
    check("rst_addr", 32'(spi_addr), 32'd0);
    check("rst_wdata", 32'(spi_wdata), 32'd0);
    check("rst_freq", 32'(spi_freq), 32'd0);
    check("rst_rdata", 32'({rsp_err, rsp_rdata}), 32'd0);
    n_reset = 1'b1;

    for (int i = 0; i < 5; i++)
      do_txn(vec[i].idx, vec[i].rw, vec[i].addr, vec[i].wdata, vec[i].freq, vec[i].sval, vec[i].exp_rd);

    // contention from reset
    do_reset();
    wr0 = n_wr; re0 = n_re;
    slave_val = 8'h5E; req_rw = 4'b0000; req = 4'b1111;
    collect(4, 4'b0000);
    check("cont_ack_count", 32'(ack_n), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("cont_order[%0d]", k), 32'(ack_log[k]), 32'(cont_exp[k]));
    check("cont_transactions", 32'((n_wr - wr0) + (n_re - re0)), 32'd4);

    // fairness: requester 0 re-requests after every ack while 3 waits
    do_reset();
    req = 4'b1001;
    collect(4, 4'b1001);
    check("fair_ack_count", 32'(ack_n), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("fair_order[%0d]", k), 32'(ack_log[k]), 32'(fair_exp[k]));

    // reset while waiting on done
    @(negedge clock);
    req_addr[23:16] = 8'h77; req_rw[2] = 1'b0; cfg_freq = 10'd9; req[2] = 1'b1;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (m_busy && m_cnt >= 5) begin
        hit = 1;
        break;
      end
    end
    check("rstmid_reached_wait", 32'(hit), 32'd1);
    check("rstmid_addr_before", 32'(spi_addr), 32'h77);
    n_reset = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_addr", 32'(spi_addr), 32'd0);
    check("rstmid_freq", 32'(spi_freq), 32'd0);
    check("rstmid_ack", 32'(ack), 32'd0);
    req[2] = 1'b0;
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack != 4'b0 || busy) bad = 1;
    end
    check("rstmid_no_spurious", 32'(bad), 32'd0);
    do_txn(1, 1'b0, 8'h44, 8'h00, 10'd7, 8'hC3, 8'hC3);

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int lat;
      bit seen;
      hold_low = 1'b1;
      @(negedge clock);
      req_rw[0] = 1'b0; req[0] = 1'b1; slave_val = 8'hEE;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clock);
        if (spi_start_re) begin
          seen = 1;
          break;
        end
      end
      check("to_issue_seen", 32'(seen), 32'd1);
      lat = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clock);
        lat++;
        if (ack != 4'b0) break;
      end
      n_chk++;
      if (lat < 101 || lat > 102) begin
        n_fail++;
        $display("FAIL to_latency: got %0d cycles expected 101..102", lat);
      end
      check("to_ack", 32'(ack), 32'd1);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_rdata", 32'(rsp_rdata), 32'd0);
      req[0] = 1'b0;
    end
`endif

    check("no_overlapping_starts", 32'(overlap), 32'd0);
    check("ack_onehot", 32'(multi_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- Round-robin arbiter and sequencer that shares one spi_master instance between NREQ on-chip requesters.
- Accepts per-requester read/write transactions (addr, wdata) and drives the master's start_wr/start_re, addr, wdata and freq.
- Tracks the master's sticky done flag and returns read data with a one-cycle ack to the granted requester.
- Sits between register-bus clients and spi_master; it is the only block that drives spi_master inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 20'd200000, clock cycles allowed per transaction before abort (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held high until matching ack
- req_rw  in  NREQ  per-requester 1 = write, 0 = read
- req_addr  in  8*NREQ  per-requester address; requester i uses bits [8i+7:8i]
- req_wdata  in  8*NREQ  per-requester write data, same packing
- cfg_freq  in  10  SCLK divider, sampled at grant
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  8  read data, valid in the ack cycle
- rsp_err  out  1  timeout flag, valid in the ack cycle
- busy  out  1  high in every state except IDLE
- spi_start_wr  out  1  to master start_wr
- spi_start_re  out  1  to master start_re
- spi_addr  out  8  to master addr
- spi_wdata  out  8  to master wdata
- spi_freq  out  10  to master freq
- spi_done  in  1  from master done (sticky; cleared by a start edge, set at end of transfer)
- spi_rdata  in  8  from master rdata

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer last_gnt = NREQ-1, so requester 0 has first priority.
- Reset is asynchronous and aborts any transaction mid-flight. No ack is issued. Requesters must re-request.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP.
- IDLE:
  - If any req bit is high, grant the first set bit searching from last_gnt+1 upward, modulo NREQ.
  - Latch g, req_rw[g], req_addr[g], req_wdata[g] and cfg_freq into spi_rw/spi_addr/spi_wdata/spi_freq.
  - Set last_gnt = g and go to ISSUE.
- ISSUE:
  - Assert spi_start_wr (if rw = 1) or spi_start_re (if rw = 0) for exactly 1 cycle.
  - Go to WAIT_CLR.
- WAIT_CLR:
  - Stay while spi_done = 1, because the master clears done 2-3 cycles after the start edge.
  - Go to WAIT_DONE when spi_done = 0. If done is already 0 (e.g. after reset), this takes 1 cycle.
- WAIT_DONE:
  - Stay while spi_done = 0.
  - On spi_done = 1 go to RESP.
- RESP:
  - ack[g] = 1 for 1 cycle.
  - rsp_rdata = spi_rdata for reads, 8'h00 for writes.
  - rsp_err = 0 unless timed out.
  - Next state is IDLE.
- spi_addr, spi_wdata and spi_freq are held constant from grant until the next grant.
- spi_start_* are low in every state except ISSUE. This guarantees a low cycle between starts, so the master's edge detector sees every transaction.
- Minimum gap between two transactions: 1 IDLE cycle after RESP.
- The granted requester's input changes after grant are ignored.
- A req dropped before grant is never served; dropping req after grant does not cancel the transaction.
- Simultaneous requests: strict round-robin.
  - Example, NREQ = 4, last_gnt = 1, req = 4'b1011: grant order is 3, 0, 1.
- The arbiter never raises ack for more than one requester in a cycle.
- ack is never asserted while req[g] is low at grant.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 20-bit counter clears on entry to ISSUE and increments in WAIT_CLR and WAIT_DONE.
  - When the counter reaches TIMEOUT_CYC, go to RESP with rsp_err = 1 and rsp_rdata = 8'h00.
  - The master is not reset; the next grant waits in WAIT_CLR as normal.
- Not defined: no counter exists, rsp_err is tied 0, and the WAIT_* states wait indefinitely.

Test Plan:
- Single read: req[0] = 1, req_rw[0] = 0, addr 8'h3C, freq 10'd4, slave model returns 8'hA5 on miso. Required response:
  - spi_start_re pulses once.
  - ack[0] pulses once after master done rises.
  - rsp_rdata = 8'hA5, rsp_err = 0.
- Single write: req[2] = 1, req_rw[2] = 1, addr 8'h12, wdata 8'h5A. Required response:
  - spi_start_wr pulses once; the master shifts out 8'hFF, 8'h12, 8'h5A.
  - ack[2] pulses once with rsp_rdata = 8'h00.
- Contention: req = 4'b1111 held from reset, each line dropped after its ack. Required response:
  - Ack order is 0, 1, 2, 3.
  - No overlapping spi_start pulses.
  - Exactly 4 master transactions.
- Fairness: req[0] re-asserted immediately after each of its acks while req[3] = 1. Required response: grants alternate 0, 3, 0, 3.
- Reset mid-transfer: assert n_reset low while in WAIT_DONE. Required response:
  - All outputs 0 immediately.
  - After release, state is IDLE with no spurious ack.
  - The next req[1] is served normally.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC = 100, spi_done is held at 0 by the bench. Required response: ack[g] arrives 101-102 cycles after ISSUE with rsp_err = 1.
